wm8731_i2c_target: RTL
======================

# wm8731_i2c_target

Cycle-accurate I2C target (responder) modelling the WM8731 audio-codec control port. It sits on the far side of the SoC's `i2c0` master in simulation and FPGA loopback builds. It decodes the codec's write-only 2-byte register protocol into a shadow register file, so the rest of the design and the bench can see exactly what configuration the MP3 player programmed. Open-drain pins are split into `_in` and `_oe` exactly as the SoC's I2C master presents them.

## Interface

- `DEV_ADDR`, default 7'h1A: 7-bit target address (WM8731 with CSB=0).
- `clk_clk`  in  1: system clock; must be at least 20× the SCL rate.
- `reset_reset`  in  1: asynchronous, active-high reset.
- `i2c_scl_in`  in  1: SCL line level. Asynchronous.
- `i2c_sda_in`  in  1: SDA line level. Asynchronous.
- `i2c_sda_oe`  out  1: 1 = pull SDA low (ACK only).
- `i2c_scl_oe`  out  1: tied 0; no clock stretching.
- `busy`  out  1: high from START to STOP.
- `wr_strobe`  out  1: one-cycle pulse when a register write commits.
- `wr_addr`  out  7: register address of the committed write.
- `wr_data`  out  9: data of the committed write.
- `codec_regs`  out  90: R0..R9 shadow registers, 9 bits each; R0 occupies [8:0].

## Operation

- **Input conditioning**
  - SCL and SDA each pass through a 2-flop synchronizer, then a 3rd flop for edge detection.
  - All decisions use the synchronized values.
- **Bus conditions**
  - START: SDA falls while SCL is high. A repeated START is also a START.
  - STOP: SDA rises while SCL is high.
  - Data bits are sampled on the SCL rising edge.
- **State machine:** IDLE, ADDR, ACK_A, BYTE1, ACK_1, BYTE2, ACK_2.
  - IDLE → ADDR on START; clear bit counter.
  - ADDR shifts 8 bits MSB-first.
    - If addr[7:1]==DEV_ADDR and R/W=0: go to ACK_A.
    - Otherwise (wrong address, or read): return to IDLE and leave SDA released, i.e. NACK. The WM8731 has no read support.
  - ACK_A → BYTE1. BYTE1 = {reg_addr[6:0], data[8]}; ACK_1 → BYTE2.
  - BYTE2 = data[7:0]; ACK_2 commits the write, then goes to BYTE1, so multiple pairs are allowed per transaction.
  - STOP in any state → IDLE. A partially received pair is discarded with no commit.
  - START in any non-IDLE state → ADDR.
- **Commit rules** (at the SCL rising edge of the 9th clock of BYTE2)
  - Address 0..9: write Rn; `wr_strobe` = 1.
  - Address 0x0F: all R0..R9 load their defaults; `wr_strobe` = 1.
  - Address 10..14 and 16..127: ACKed, no register change, `wr_strobe` still pulses.
- **Reset**
  - `i2c_sda_oe` = 0, `busy` = 0, `wr_strobe` = 0, `wr_addr` = 0, `wr_data` = 0, state = IDLE.
  - `codec_regs` = defaults: R0 097, R1 097, R2 079, R3 079, R4 00A, R5 008, R6 09F, R7 00A, R8 000, R9 000 (hex).
  - Asserting reset mid-transaction releases SDA immediately. The target then ignores the bus until the next START.

## Timing

- Synchronizer latency is 2 clk. Any bus event acts on the FSM 3 clk after the pin changes.
- **ACK drive**
  - `i2c_sda_oe` rises on the first synchronized SCL falling edge after the 8th data bit.
  - It falls on the synchronized SCL falling edge ending the 9th clock.
  - It is registered, so there is no combinational path from pins.
- **Write outputs**
  - `wr_strobe` fires 1 clk after the 9th-clock SCL rise of BYTE2.
  - `wr_addr`/`wr_data` are valid in that same cycle and held until the next commit.
  - `codec_regs` updates in the same cycle as `wr_strobe`.
- `busy` rises 1 clk after START is detected and falls 1 clk after STOP is detected.
- Simultaneous SDA and SCL change in the same sample: treated as a data-phase change; no START/STOP is detected.

## Structure

- Package `wm8731_pkg`:
  - `WM_NUM_REGS` = 10, `WM_RESET_ADDR` = 7'h0F.
  - Default-value array `WM_REG_DEFAULTS`.
  - State enum `i2c_tgt_state_t`.
- Sub-module `i2c_line_sync`: one instance per line (SCL, SDA). It holds the synchronizer plus edge flops and outputs `level`, `rise`, `fall`.

## Test plan

- Reset → `codec_regs` = defaults concatenation; `i2c_sda_oe` = 0; `busy` = 0.
- Write 0x34, 0x0C, 0x00 (R6 = 0x000), then STOP →
  - ACK on all three bytes.
  - One `wr_strobe` with `wr_addr` = 6, `wr_data` = 0x000.
  - R6 = 0x000.
- Address 0x36 (7'h1B), then address 0x35 (read) → no ACK on either; no `wr_strobe`; `codec_regs` unchanged.
- One transaction: 0x34, {R4: 0x08, 0x12}, {R7: 0x0E, 0x42}, STOP → two strobes; R4 = 0x012, R7 = 0x042.
- Partial and reset-register cases:
  - 0x34, 0x0E, then STOP mid-BYTE2 → no commit.
  - Next, 0x34, 0x1E, 0x00 (write R15) → all registers return to defaults.
- Repeated START after BYTE1, then a full R0 = 0x117 write → only the R0 commit occurs. Also assert `reset_reset` during BYTE2 → `i2c_sda_oe` is 0 within 1 clk.

Source files
------------

// File: rtl/wm8731_pkg.sv
// Shared constants and types for the WM8731 control-port I2C target.
package wm8731_pkg;

  localparam int WM_NUM_REGS = 10;
  localparam logic [6:0] WM_RESET_ADDR = 7'h0F;

  // Packed so element [0] lands in bits [8:0], matching the codec_regs layout.
  localparam logic [WM_NUM_REGS-1:0][8:0] WM_REG_DEFAULTS = {
    9'h000, 9'h000, 9'h00A, 9'h09F, 9'h008,
    9'h00A, 9'h079, 9'h079, 9'h097, 9'h097
  };

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ACK_A,
    ST_BYTE1,
    ST_ACK_1,
    ST_BYTE2,
    ST_ACK_2
  } i2c_tgt_state_t;

endpackage

// File: rtl/wm8731_i2c_target_line_sync.sv
// Two-flop synchronizer plus one edge-detect flop for an asynchronous bus line.
module i2c_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic line,
  output logic level,
  output logic rise,
  output logic fall
);

  // Reset to the idle-high bus level so reset release makes no phantom edges.
  logic [2:0] sh;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sh <= 3'b111;
    else     sh <= {sh[1:0], line};
  end

  assign level = sh[1];
  assign rise  = sh[1] & ~sh[2];
  assign fall  = ~sh[1] & sh[2];

endmodule

// File: rtl/wm8731_i2c_target.sv
// WM8731 control-port I2C target: decodes 2-byte register writes into a shadow
// register file; write-only, no clock stretching, ACK driven as a registered output.
module wm8731_i2c_target
  import wm8731_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h1A
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic        i2c_scl_in,
  input  logic        i2c_sda_in,
  output logic        i2c_sda_oe,
  output logic        i2c_scl_oe,
  output logic        busy,
  output logic        wr_strobe,
  output logic [6:0]  wr_addr,
  output logic [8:0]  wr_data,
  output logic [89:0] codec_regs
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_line_sync u_scl_sync (
    .clk   (clk_clk),
    .rst   (reset_reset),
    .line  (i2c_scl_in),
    .level (scl_lvl),
    .rise  (scl_rise),
    .fall  (scl_fall)
  );

  i2c_line_sync u_sda_sync (
    .clk   (clk_clk),
    .rst   (reset_reset),
    .line  (i2c_sda_in),
    .level (sda_lvl),
    .rise  (sda_rise),
    .fall  (sda_fall)
  );

  i2c_tgt_state_t              state;
  logic [2:0]                  bit_cnt;
  logic [7:0]                  shift;
  logic [7:0]                  byte1;
  logic [7:0]                  rx_byte;
  logic                        start_det, stop_det, commit;
  logic [WM_NUM_REGS-1:0][8:0] regs;

  // An SCL edge in the same sample as the SDA edge makes it a data change.
  assign start_det = sda_fall & scl_lvl & ~scl_rise;
  assign stop_det  = sda_rise & scl_lvl & ~scl_rise;
  assign rx_byte   = {shift[6:0], sda_lvl};
  // The ACK_2 rising edge seen while SDA is held low is the 9th clock of BYTE2.
  assign commit    = (state == ST_ACK_2) & i2c_sda_oe & scl_rise;

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state      <= ST_IDLE;
      bit_cnt    <= 3'd0;
      shift      <= 8'd0;
      byte1      <= 8'd0;
      i2c_sda_oe <= 1'b0;
      busy       <= 1'b0;
    end else if (start_det) begin
      state      <= ST_ADDR;
      bit_cnt    <= 3'd0;
      i2c_sda_oe <= 1'b0;
      busy       <= 1'b1;
    end else if (stop_det) begin
      state      <= ST_IDLE;
      i2c_sda_oe <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        ST_ADDR, ST_BYTE1, ST_BYTE2: begin
          if (scl_rise) begin
            shift   <= rx_byte;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (state == ST_ADDR)
                state <= (rx_byte == {DEV_ADDR, 1'b0}) ? ST_ACK_A : ST_IDLE;
              else if (state == ST_BYTE1) begin
                byte1 <= rx_byte;
                state <= ST_ACK_1;
              end else
                state <= ST_ACK_2;
            end
          end
        end
        ST_ACK_A, ST_ACK_1, ST_ACK_2: begin
          // First falling edge starts the ACK slot, the second ends it.
          if (scl_fall) begin
            if (!i2c_sda_oe) begin
              i2c_sda_oe <= 1'b1;
            end else begin
              i2c_sda_oe <= 1'b0;
              bit_cnt    <= 3'd0;
              state      <= (state == ST_ACK_1) ? ST_BYTE2 : ST_BYTE1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      wr_strobe <= 1'b0;
      wr_addr   <= 7'd0;
      wr_data   <= 9'd0;
      regs      <= WM_REG_DEFAULTS;
    end else begin
      wr_strobe <= commit;
      if (commit) begin
        wr_addr <= byte1[7:1];
        wr_data <= {byte1[0], shift};
        if (byte1[7:1] == WM_RESET_ADDR)
          regs <= WM_REG_DEFAULTS;
        else
          for (int i = 0; i < WM_NUM_REGS; i++)
            if (byte1[7:1] == 7'(i)) regs[i] <= {byte1[0], shift};
      end
    end
  end

  assign codec_regs = regs;
  assign i2c_scl_oe = 1'b0;

endmodule
